// File: rtl/dma_axi_simple_core_write.sv
// Write engine of the simple AXI DMA: drains the shared data FIFO into AXI
// AW/W/B bursts, segmented with the same misalign/chunk rules as the read side.
module dma_axi_simple_core_write #(
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int AXI_WIDTH_DS  = AXI_WIDTH_DA/8,
  parameter int AXI_WIDTH_DSB = $clog2(AXI_WIDTH_DS),
  parameter int FIFO_WIDTH    = AXI_WIDTH_DS+AXI_WIDTH_DA,
  parameter int FIFO_AW       = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  output logic [AXI_WIDTH_ID-1:0] M_AWID,
  output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [AXI_WIDTH_DA-1:0] M_WDATA,
  output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
  output logic                    M_WLAST,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [AXI_WIDTH_ID-1:0] M_BID,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  input  logic                    DMA_EN,
  input  logic                    DMA_GO,
  output logic                    DMA_BUSY,
  output logic                    DMA_DONE,
  output logic                    DMA_ERR,
  input  logic [31:0]             DMA_DST,
  input  logic [15:0]             DMA_BNUM,
  input  logic [7:0]              DMA_CHUNK,
  output logic                    fifo_rd_rdy,
  input  logic                    fifo_rd_vld,
  input  logic [FIFO_WIDTH-1:0]   fifo_rd_dat,
  input  logic [FIFO_AW:0]        fifo_items
);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] DS16  = 16'(AXI_WIDTH_DS);
  localparam logic [15:0] MAXCH = 16'(FIFO_DEPTH*AXI_WIDTH_DS);
  localparam logic [2:0]  SZ_FULL = 3'(AXI_WIDTH_DSB);
  localparam logic [AXI_WIDTH_DS-1:0] ONE_S = 1;

  typedef enum logic [2:0] {ST_READY, ST_MISALIGN, ST_ALIGN, ST_WAIT, ST_AW, ST_W, ST_B} state_t;
  state_t state, state_nx;

  logic [AXI_WIDTH_AD-1:0] addr, addr_nx;
  logic [15:0] rem, chunk, inc, chunk_sel, ch_rnd, b_inc;
  logic [8:0]  len, beat, b_len;
  logic [2:0]  awsize, b_size;
  logic [AXI_WIDTH_DS-1:0]  wstrb, b_strb;
  logic [AXI_WIDTH_DSB-1:0] off;
  logic [AXI_WIDTH_ID-1:0]  awid;
  logic awvalid, busy, done, err, in_w, w_fire, w_last, start;
  logic unused_bits;

  assign unused_bits = ^{M_BID, fifo_rd_dat[FIFO_WIDTH-1:AXI_WIDTH_DA]};

  assign off     = addr[AXI_WIDTH_DSB-1:0];
  assign addr_nx = addr + AXI_WIDTH_AD'(inc);
  assign in_w    = (state == ST_W);
  assign w_fire  = M_WVALID && M_WREADY;
  assign w_last  = (beat == len);
  assign start   = DMA_GO && !done && (DMA_BNUM != 16'd0);

  always_comb begin
    ch_rnd = {8'h00, DMA_CHUNK} & ~(DS16 - 16'd1);
    if (DMA_BNUM <= DS16)                 chunk_sel = DMA_BNUM;
    else if ({8'h00, DMA_CHUNK} <= DS16)  chunk_sel = DS16;
    else if (ch_rnd > MAXCH)              chunk_sel = MAXCH;
    else                                  chunk_sel = ch_rnd;
  end

  // Burst shape for the next segment; only latched in ST_MISALIGN/ST_ALIGN.
  // A sub-word chunk (short transfer) falls through to the single-byte path.
  always_comb begin
    b_size = SZ_FULL;
    b_len  = 9'd1;
    b_inc  = DS16;
    b_strb = '1;
    if (state == ST_MISALIGN) begin
      if (rem < DS16 - 16'(off)) begin
        b_size = 3'd0;
        b_inc  = 16'd1;
        b_strb = ONE_S << off;
      end else begin
        b_inc  = DS16 - 16'(off);
        b_strb = '1 << off;
      end
    end else if (rem >= chunk && chunk >= DS16) begin
      b_len = 9'(chunk >> AXI_WIDTH_DSB);
      b_inc = 16'(b_len) << AXI_WIDTH_DSB;
    end else if (rem >= DS16) begin
      b_len = 9'(rem >> AXI_WIDTH_DSB);
      b_inc = 16'(b_len) << AXI_WIDTH_DSB;
    end else begin
      b_size = 3'd0;
      b_inc  = 16'd1;
      b_strb = ONE_S;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_READY:    if (start) state_nx = (DMA_DST[AXI_WIDTH_DSB-1:0] != '0) ? ST_MISALIGN : ST_ALIGN;
      ST_MISALIGN: state_nx = ST_WAIT;
      ST_ALIGN:    state_nx = ST_WAIT;
      ST_WAIT:     if (9'(fifo_items) >= len) state_nx = ST_AW;
      ST_AW:       if (M_AWREADY) state_nx = ST_W;
      ST_W:        if (w_fire && w_last) state_nx = ST_B;
      ST_B: if (M_BVALID) begin
        if (rem == inc) state_nx = ST_READY;
        else state_nx = (addr_nx[AXI_WIDTH_DSB-1:0] != '0) ? ST_MISALIGN : ST_ALIGN;
      end
      default:     state_nx = ST_READY;
    endcase
    if (!DMA_EN) state_nx = ST_READY;
  end

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) state <= ST_READY;
    else        state <= state_nx;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr <= '0; rem <= '0; chunk <= '0; inc <= '0; len <= '0; beat <= '0;
      awsize <= '0; wstrb <= '0; awid <= '0; awvalid <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else if (!DMA_EN) begin
      addr <= '0; rem <= '0; chunk <= '0; inc <= '0; len <= '0; beat <= '0;
      awsize <= '0; wstrb <= '0; awid <= '0; awvalid <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else begin
      case (state)
        ST_READY: begin
          if (!DMA_GO) done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            err   <= 1'b0;
            addr  <= AXI_WIDTH_AD'(DMA_DST);
            rem   <= DMA_BNUM;
            chunk <= chunk_sel;
          end
        end
        ST_MISALIGN, ST_ALIGN: begin
          len    <= b_len;
          inc    <= b_inc;
          awsize <= b_size;
          wstrb  <= b_strb;
        end
        ST_WAIT: if (9'(fifo_items) >= len) begin
          awvalid <= 1'b1;
          awid    <= awid + AXI_WIDTH_ID'(1);
        end
        ST_AW: if (M_AWREADY) begin
          awvalid <= 1'b0;
          beat    <= 9'd1;
        end
        ST_W: if (w_fire) beat <= beat + 9'd1;
        ST_B: if (M_BVALID) begin
          if (M_BRESP != 2'b00) err <= 1'b1;
          addr <= addr_nx;
          rem  <= rem - inc;
          if (rem == inc) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign M_AWID      = awid;
  assign M_AWADDR    = awvalid ? addr : '0;
  assign M_AWLEN     = awvalid ? 8'(len - 9'd1) : 8'd0;
  assign M_AWSIZE    = awvalid ? awsize : 3'd0;
  assign M_AWBURST   = 2'b01;
  assign M_AWVALID   = awvalid;
  assign M_WVALID    = in_w && fifo_rd_vld;
  assign fifo_rd_rdy = in_w && M_WREADY;
  assign M_WDATA     = in_w ? fifo_rd_dat[AXI_WIDTH_DA-1:0] : '0;
  assign M_WSTRB     = in_w ? wstrb : '0;
  assign M_WLAST     = in_w && w_last;
  assign M_BREADY    = (state == ST_B);
  assign DMA_BUSY    = busy;
  assign DMA_DONE    = done;
  assign DMA_ERR     = err;
endmodule
